// File: rtl/gelato_reconv_stack_if.sv
// Request/response bus of the SIMT reconvergence stack.
// The master issues INIT/SPLIT/JOIN requests. The slave returns one registered update per accepted request.
interface gelato_reconv_stack_if #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 32,
    parameter int PC_WIDTH    = 32
);
    localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    logic                   req_valid;
    logic                   req_ready;
    logic [1:0]             req_op;
    logic [WID_W-1:0]       req_wid;
    logic [NUM_THREADS-1:0] req_mask;
    logic [PC_WIDTH-1:0]    req_pc;
    logic [PC_WIDTH-1:0]    req_npc;
    logic [PC_WIDTH-1:0]    req_rpc;

    logic                   upd_valid;
    logic [WID_W-1:0]       upd_wid;
    logic [PC_WIDTH-1:0]    upd_pc;
    logic [NUM_THREADS-1:0] upd_mask;
    logic                   upd_err;

    modport master (
        output req_valid, req_op, req_wid, req_mask, req_pc, req_npc, req_rpc,
        input  req_ready, upd_valid, upd_wid, upd_pc, upd_mask, upd_err
    );

    modport slave (
        input  req_valid, req_op, req_wid, req_mask, req_pc, req_npc, req_rpc,
        output req_ready, upd_valid, upd_wid, upd_pc, upd_mask, upd_err
    );
endinterface

// File: rtl/gelato_reconv_stack.sv
// Per-warp SIMT divergence/reconvergence stack.
// A divergent SPLIT pushes two entries. A JOIN at the current reconvergence PC pops one entry.
module gelato_reconv_stack #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 32,
    parameter int DEPTH       = 8,
    parameter int PC_WIDTH    = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rdy,
    gelato_reconv_stack_if.slave      bus
);
    localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int DW    = $clog2(DEPTH + 1);
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        OP_INIT  = 2'b00,
        OP_SPLIT = 2'b01,
        OP_JOIN  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    logic [NUM_THREADS-1:0] cur_mask_q [NUM_WARPS];
    logic [NUM_THREADS-1:0] cur_mask_d [NUM_WARPS];
    logic [PC_WIDTH-1:0]    cur_rpc_q  [NUM_WARPS];
    logic [PC_WIDTH-1:0]    cur_rpc_d  [NUM_WARPS];
    logic [DW-1:0]          depth_q    [NUM_WARPS];
    logic [DW-1:0]          depth_d    [NUM_WARPS];

    logic [PC_WIDTH-1:0]    stk_pc_q   [NUM_WARPS][DEPTH];
    logic [PC_WIDTH-1:0]    stk_pc_d   [NUM_WARPS][DEPTH];
    logic [PC_WIDTH-1:0]    stk_rpc_q  [NUM_WARPS][DEPTH];
    logic [PC_WIDTH-1:0]    stk_rpc_d  [NUM_WARPS][DEPTH];
    logic [NUM_THREADS-1:0] stk_mask_q [NUM_WARPS][DEPTH];
    logic [NUM_THREADS-1:0] stk_mask_d [NUM_WARPS][DEPTH];

    logic                   upd_valid_q, upd_valid_d;
    logic [WID_W-1:0]       upd_wid_q,   upd_wid_d;
    logic [PC_WIDTH-1:0]    upd_pc_q,    upd_pc_d;
    logic [NUM_THREADS-1:0] upd_mask_q,  upd_mask_d;
    logic                   upd_err_q,   upd_err_d;

    logic                   accept;
    logic                   wid_ok;
    logic [WID_W-1:0]       widx;
    op_e                    op;
    logic [NUM_THREADS-1:0] cm;
    logic [PC_WIDTH-1:0]    cr;
    logic [DW-1:0]          dp;
    logic [NUM_THREADS-1:0] taken;
    logic [IW-1:0]          lo_idx;
    logic [IW-1:0]          hi_idx;
    logic [IW-1:0]          top_idx;

    // An out-of-range wid is redirected to warp 0 only for the reads below.
    // Such a request is rejected and changes no state.
    always_comb begin
        accept  = bus.req_valid && rdy;
        wid_ok  = int'(bus.req_wid) < NUM_WARPS;
        widx    = wid_ok ? bus.req_wid : '0;
        op      = op_e'(bus.req_op);
        cm      = cur_mask_q[widx];
        cr      = cur_rpc_q[widx];
        dp      = depth_q[widx];
        taken   = bus.req_mask & cm;
        lo_idx  = IW'(dp);
        hi_idx  = IW'(dp + DW'(1));
        top_idx = IW'(dp - DW'(1));
    end

    always_comb begin
        cur_mask_d  = cur_mask_q;
        cur_rpc_d   = cur_rpc_q;
        depth_d     = depth_q;
        stk_pc_d    = stk_pc_q;
        stk_rpc_d   = stk_rpc_q;
        stk_mask_d  = stk_mask_q;
        upd_valid_d = accept;
        upd_wid_d   = upd_wid_q;
        upd_pc_d    = upd_pc_q;
        upd_mask_d  = upd_mask_q;
        upd_err_d   = upd_err_q;

        if (accept) begin
            upd_wid_d  = bus.req_wid;
            upd_pc_d   = bus.req_pc;
            upd_mask_d = cm;
            upd_err_d  = 1'b0;
            if (!wid_ok || op == OP_RSVD) begin
                upd_err_d  = 1'b1;
                upd_mask_d = '0;
            end else begin
                case (op)
                    OP_INIT: begin
                        cur_mask_d[widx] = bus.req_mask;
                        cur_rpc_d[widx]  = '1;
                        depth_d[widx]    = '0;
                        upd_mask_d       = bus.req_mask;
                    end
                    OP_SPLIT: begin
                        if (taken == cm) begin
                            upd_pc_d = bus.req_pc;
                        end else if (taken == '0) begin
                            upd_pc_d = bus.req_npc;
                        end else if (int'(dp) <= DEPTH - 2) begin
                            // Lower entry resumes the enclosing region at the reconvergence PC.
                            // Upper entry runs the not-taken side first.
                            stk_pc_d[widx][lo_idx]   = bus.req_rpc;
                            stk_rpc_d[widx][lo_idx]  = cr;
                            stk_mask_d[widx][lo_idx] = cm;
                            stk_pc_d[widx][hi_idx]   = bus.req_npc;
                            stk_rpc_d[widx][hi_idx]  = bus.req_rpc;
                            stk_mask_d[widx][hi_idx] = cm & ~taken;
                            depth_d[widx]            = dp + DW'(2);
                            cur_mask_d[widx]         = taken;
                            cur_rpc_d[widx]          = bus.req_rpc;
                            upd_mask_d               = taken;
                        end else begin
                            upd_err_d = 1'b1;
                        end
                    end
                    OP_JOIN: begin
                        if (bus.req_pc == cr && dp != '0) begin
                            cur_mask_d[widx] = stk_mask_q[widx][top_idx];
                            cur_rpc_d[widx]  = stk_rpc_q[widx][top_idx];
                            depth_d[widx]    = dp - DW'(1);
                            upd_pc_d         = stk_pc_q[widx][top_idx];
                            upd_mask_d       = stk_mask_q[widx][top_idx];
                        end
                    end
                    default: begin
                        upd_err_d  = 1'b1;
                        upd_mask_d = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_mask_q  <= '{default: '0};
            cur_rpc_q   <= '{default: '1};
            depth_q     <= '{default: '0};
            upd_valid_q <= 1'b0;
            upd_wid_q   <= '0;
            upd_pc_q    <= '0;
            upd_mask_q  <= '0;
            upd_err_q   <= 1'b0;
        end else begin
            cur_mask_q  <= cur_mask_d;
            cur_rpc_q   <= cur_rpc_d;
            depth_q     <= depth_d;
            upd_valid_q <= upd_valid_d;
            upd_wid_q   <= upd_wid_d;
            upd_pc_q    <= upd_pc_d;
            upd_mask_q  <= upd_mask_d;
            upd_err_q   <= upd_err_d;
        end
    end

    always_ff @(posedge clk) begin
        stk_pc_q   <= stk_pc_d;
        stk_rpc_q  <= stk_rpc_d;
        stk_mask_q <= stk_mask_d;
    end

    assign bus.req_ready = rdy;
    assign bus.upd_valid = upd_valid_q;
    assign bus.upd_wid   = upd_wid_q;
    assign bus.upd_pc    = upd_pc_q;
    assign bus.upd_mask  = upd_mask_q;
    assign bus.upd_err   = upd_err_q;
endmodule

// File: tb/tb_gelato_reconv_stack.sv
// Directed bench for gelato_reconv_stack.
// A vector table drives single requests; hand sequences cover nesting overflow and mid-flight reset.
module tb_gelato_reconv_stack;
    localparam logic [1:0] INIT  = 2'b00;
    localparam logic [1:0] SPLIT = 2'b01;
    localparam logic [1:0] JOIN  = 2'b10;
    localparam logic [1:0] RSVD  = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  wid;
        logic [31:0] mask;
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] rpc;
        logic        rdy;
        logic        vld;
        logic        e_vld;
        logic [31:0] e_pc;
        logic [31:0] e_mask;
        logic        e_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rdy = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    gelato_reconv_stack_if #(.NUM_WARPS(4), .NUM_THREADS(32), .PC_WIDTH(32)) bus ();

    gelato_reconv_stack #(
        .NUM_WARPS(4), .NUM_THREADS(32), .DEPTH(8), .PC_WIDTH(32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rdy   (rdy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [1:0] wid,
                                input logic [31:0] mask, input logic [31:0] pc,
                                input logic [31:0] npc, input logic [31:0] rpc,
                                input logic r, input logic v, input logic e_vld,
                                input logic [31:0] e_pc, input logic [31:0] e_mask,
                                input logic e_err);
        vec_t t;
        t.op = op; t.wid = wid; t.mask = mask; t.pc = pc; t.npc = npc; t.rpc = rpc;
        t.rdy = r; t.vld = v; t.e_vld = e_vld; t.e_pc = e_pc; t.e_mask = e_mask;
        t.e_err = e_err;
        return t;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        bus.req_valid = v.vld;
        bus.req_op    = v.op;
        bus.req_wid   = v.wid;
        bus.req_mask  = v.mask;
        bus.req_pc    = v.pc;
        bus.req_npc   = v.npc;
        bus.req_rpc   = v.rpc;
        rdy           = v.rdy;
        @(posedge clk);
        #1;
        chk({tag, ".ready"}, 64'(bus.req_ready), 64'(v.rdy));
        chk({tag, ".valid"}, 64'(bus.upd_valid), 64'(v.e_vld));
        if (v.e_vld) begin
            chk({tag, ".pc"},   64'(bus.upd_pc),   64'(v.e_pc));
            chk({tag, ".mask"}, 64'(bus.upd_mask), 64'(v.e_mask));
            chk({tag, ".err"},  64'(bus.upd_err),  64'(v.e_err));
            chk({tag, ".wid"},  64'(bus.upd_wid),  64'(v.wid));
        end
        bus.req_valid = 1'b0;
        rdy           = 1'b1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, ".valid"}, 64'(bus.upd_valid), 64'd0);
        chk({tag, ".err"},   64'(bus.upd_err),   64'd0);
        chk({tag, ".wid"},   64'(bus.upd_wid),   64'd0);
        chk({tag, ".pc"},    64'(bus.upd_pc),    64'd0);
        chk({tag, ".mask"},  64'(bus.upd_mask),  64'd0);
    endtask

    vec_t vt[21];
    logic [31:0] curm[5];
    logic [31:0] reqm[4];

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_wid   = '0;
        bus.req_mask  = '0;
        bus.req_pc    = '0;
        bus.req_npc   = '0;
        bus.req_rpc   = '0;

        // w0 / w3 single-request table: basic function, uniform splits, rdy gaps, interleaving
        vt[0]  = mk(INIT,  0, 32'hFFFFFFFF, 32'h100, 32'h0,   32'h0,   1, 1, 1, 32'h100,      32'hFFFFFFFF, 0);
        vt[1]  = mk(SPLIT, 0, 32'h0000FFFF, 32'h200, 32'h180, 32'h300, 1, 1, 1, 32'h200,      32'h0000FFFF, 0);
        vt[2]  = mk(JOIN,  0, 32'h0,        32'h300, 32'h0,   32'h0,   1, 1, 1, 32'h180,      32'hFFFF0000, 0);
        vt[3]  = mk(JOIN,  0, 32'h0,        32'h300, 32'h0,   32'h0,   1, 1, 1, 32'h300,      32'hFFFFFFFF, 0);
        vt[4]  = mk(JOIN,  0, 32'h0,        32'h300, 32'h0,   32'h0,   1, 1, 1, 32'h300,      32'hFFFFFFFF, 0);
        vt[5]  = mk(SPLIT, 0, 32'hFFFFFFFF, 32'h400, 32'h480, 32'h500, 1, 1, 1, 32'h400,      32'hFFFFFFFF, 0);
        vt[6]  = mk(SPLIT, 0, 32'h0,        32'h400, 32'h480, 32'h500, 1, 1, 1, 32'h480,      32'hFFFFFFFF, 0);
        vt[7]  = mk(JOIN,  0, 32'h0,        32'hFFFFFFFF, 32'h0, 32'h0, 1, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        vt[8]  = mk(RSVD,  0, 32'h1234,     32'h77,  32'h0,   32'h0,   1, 1, 1, 32'h77,       32'h0,        1);
        vt[9]  = mk(INIT,  0, 32'h1,        32'h900, 32'h0,   32'h0,   0, 1, 0, 32'h0,        32'h0,        0);
        vt[10] = mk(INIT,  0, 32'h1,        32'h900, 32'h0,   32'h0,   1, 0, 0, 32'h0,        32'h0,        0);
        vt[11] = mk(INIT,  3, 32'h000000FF, 32'h10,  32'h0,   32'h0,   1, 1, 1, 32'h10,       32'h000000FF, 0);
        vt[12] = mk(SPLIT, 3, 32'h0000000F, 32'h20,  32'h28,  32'h30,  1, 1, 1, 32'h20,       32'h0000000F, 0);
        vt[13] = mk(SPLIT, 0, 32'hF0F0F0F0, 32'h600, 32'h680, 32'h700, 1, 1, 1, 32'h600,      32'hF0F0F0F0, 0);
        vt[14] = mk(JOIN,  3, 32'h0,        32'h30,  32'h0,   32'h0,   0, 1, 0, 32'h0,        32'h0,        0);
        vt[15] = mk(JOIN,  3, 32'h0,        32'h30,  32'h0,   32'h0,   1, 1, 1, 32'h28,       32'h000000F0, 0);
        vt[16] = mk(JOIN,  0, 32'h0,        32'h700, 32'h0,   32'h0,   1, 1, 1, 32'h680,      32'h0F0F0F0F, 0);
        vt[17] = mk(JOIN,  3, 32'h0,        32'h30,  32'h0,   32'h0,   1, 1, 1, 32'h30,       32'h000000FF, 0);
        vt[18] = mk(JOIN,  0, 32'h0,        32'h700, 32'h0,   32'h0,   0, 1, 0, 32'h0,        32'h0,        0);
        vt[19] = mk(JOIN,  0, 32'h0,        32'h700, 32'h0,   32'h0,   1, 1, 1, 32'h700,      32'hFFFFFFFF, 0);
        vt[20] = mk(JOIN,  3, 32'h0,        32'h30,  32'h0,   32'h0,   1, 1, 1, 32'h30,       32'h000000FF, 0);

        // Active-mask chain for nested splits on w2, and the taken masks that produce it
        curm[0] = 32'hFFFFFFFF; curm[1] = 32'h0000FFFF; curm[2] = 32'h000000FF;
        curm[3] = 32'h0000000F; curm[4] = 32'h00000003;
        reqm[0] = 32'h0000FFFF; reqm[1] = 32'h000000FF; reqm[2] = 32'h0000000F;
        reqm[3] = 32'h00000003;

        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            apply(vt[i], $sformatf("vec%0d", i));
        end

        // Four nested divergent splits fill DEPTH=8, the fifth overflows, eight joins unwind
        apply(mk(INIT, 2, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 1, 1, 1, 32'h0, 32'hFFFFFFFF, 0), "nest.init");
        for (int k = 0; k < 4; k++) begin
            apply(mk(SPLIT, 2, reqm[k], 32'h1000 + 32'(k) * 32'h10, 32'h2000 + 32'(k) * 32'h10,
                     32'h3000 + 32'(k) * 32'h10, 1, 1, 1, 32'h1000 + 32'(k) * 32'h10, curm[k+1], 0),
                  $sformatf("nest.split%0d", k));
        end
        apply(mk(SPLIT, 2, 32'h1, 32'h1400, 32'h2400, 32'h3400, 1, 1, 1, 32'h1400, 32'h3, 1), "nest.ovf");
        for (int k = 3; k >= 0; k--) begin
            apply(mk(JOIN, 2, 32'h0, 32'h3000 + 32'(k) * 32'h10, 32'h0, 32'h0, 1, 1, 1,
                     32'h2000 + 32'(k) * 32'h10, curm[k] & ~curm[k+1], 0),
                  $sformatf("nest.join%0d_nt", k));
            apply(mk(JOIN, 2, 32'h0, 32'h3000 + 32'(k) * 32'h10, 32'h0, 32'h0, 1, 1, 1,
                     32'h3000 + 32'(k) * 32'h10, curm[k], 0),
                  $sformatf("nest.join%0d_rc", k));
        end
        apply(mk(JOIN, 2, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0, 1, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0), "nest.empty");

        // Reset with w1 at depth 4 and a response in flight
        apply(mk(INIT,  1, 32'h000000FF, 32'h0,  32'h0,  32'h0,  1, 1, 1, 32'h0,  32'hFF, 0), "rst.init");
        apply(mk(SPLIT, 1, 32'h0000000F, 32'h10, 32'h18, 32'h20, 1, 1, 1, 32'h10, 32'h0F, 0), "rst.split0");
        apply(mk(SPLIT, 1, 32'h00000003, 32'h10, 32'h14, 32'h40, 1, 1, 1, 32'h10, 32'h03, 0), "rst.split1");
        apply(mk(JOIN,  1, 32'h0,        32'h40, 32'h0,  32'h0,  1, 1, 1, 32'h14, 32'h0C, 0), "rst.inflight");
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("rst.async");
        @(posedge clk);
        #1;
        chk_outputs_zero("rst.held");
        rst_n = 1'b1;
        apply(mk(JOIN, 1, 32'h0, 32'h40,       32'h0, 32'h0, 1, 1, 1, 32'h40,       32'h0, 0), "rst.join");
        apply(mk(JOIN, 1, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0, 1, 1, 1, 32'hFFFFFFFF, 32'h0, 0), "rst.join_sentinel");

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
